// File: rtl/frog_if.sv
// frog_if: buttons and car grid in, frog position and game status out.
// master drives buttons/cars; slave is the game-logic stage.
interface frog_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic [54:0] car_cols;
  logic [43:0] car_rows;
  logic [4:0]  frog_col;
  logic [3:0]  frog_row;
  logic        frog_visible;
  logic [1:0]  lives;
  logic [7:0]  score;
  logic [1:0]  game_state;

  modport master (
    output btn_up, btn_down, btn_left, btn_right,
    output car_cols, car_rows,
    input  frog_col, frog_row, frog_visible,
    input  lives, score, game_state
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right,
    input  car_cols, car_rows,
    output frog_col, frog_row, frog_visible,
    output lives, score, game_state
  );
endinterface

// File: rtl/frog_controller.sv
// frog_controller: frog movement, car collision, lives, score, game FSM.
// Optional macro FROG_WRAP_EN wraps columns and wide-car bounds mod 20.
module frog_controller #(
  parameter int TICK_DIV      = 416667,
  parameter int MOVE_COOLDOWN = 8,
  parameter int HIT_TICKS     = 60,
  parameter int WIN_TICKS     = 60,
  parameter int START_LIVES   = 3
) (
  input logic   clk,
  input logic   rst,
  frog_if.slave bus
);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [7:0]  CD_LOAD  = 8'(MOVE_COOLDOWN);
  localparam logic [15:0] HIT_LAST = 16'(HIT_TICKS - 1);
  localparam logic [15:0] WIN_LAST = 16'(WIN_TICKS - 1);
  localparam logic [1:0]  LIVES0   = 2'(START_LIVES);
  localparam logic [4:0]  COL0     = 5'd10;
  localparam logic [3:0]  ROW0     = 4'd14;
`ifdef FROG_WRAP_EN
  localparam logic [4:0]  LEFT_END  = 5'd19;
  localparam logic [4:0]  RIGHT_END = 5'd0;
`else
  localparam logic [4:0]  LEFT_END  = 5'd0;
  localparam logic [4:0]  RIGHT_END = 5'd19;
`endif

  typedef enum logic [1:0] {PLAY, HIT, WIN, OVER} state_e;

  state_e        state_q;
  logic [3:0]    s1_q, s2_q, prev_q;
  logic [DW-1:0] div_q;
  logic [7:0]    cd_q;
  logic [15:0]   tcnt_q;
  logic [4:0]    col_q, col_d;
  logic [3:0]    row_q, row_d;
  logic          vis_q;
  logic [1:0]    lives_q;
  logic [7:0]    score_q;

  logic [3:0] btn;
  logic [3:0] edg;
  logic       tick;
  logic       hit;
  logic       moved;

  // bit order: 0 up, 1 down, 2 left, 3 right
  assign btn  = {bus.btn_right, bus.btn_left,
                 bus.btn_down, bus.btn_up};
  assign edg  = s2_q & ~prev_q;
  assign tick = (div_q == DIV_LAST);

  assign bus.frog_col     = col_q;
  assign bus.frog_row     = row_q;
  assign bus.frog_visible = vis_q;
  assign bus.lives        = lives_q;
  assign bus.score        = score_q;
  assign bus.game_state   = state_q;

  function automatic logic wide_hit(logic [4:0] cx,
                                    logic [4:0] fc);
`ifdef FROG_WRAP_EN
    logic [5:0] d;
    d = (fc >= cx) ? {1'b0, fc} - {1'b0, cx}
                   : {1'b0, fc} + 6'd20 - {1'b0, cx};
    return d <= 6'd3;
`else
    return ({1'b0, cx} <= {1'b0, fc}) &&
           ({1'b0, fc} <= {1'b0, cx} + 6'd3);
`endif
  endfunction

  // Collision of the registered frog cell against all eleven cars
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < 11; k++) begin
      if (bus.car_rows[4*k +: 4] == row_q) begin
        if (k < 4) begin
          if (wide_hit(bus.car_cols[5*k +: 5], col_q))
            hit = 1'b1;
        end else if (bus.car_cols[5*k +: 5] == col_q) begin
          hit = 1'b1;
        end
      end
    end
  end

  // Highest-priority button edge picks the next frog cell
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    moved = 1'b0;
    if (state_q == PLAY && cd_q == 8'd0) begin
      moved = |edg;
      if (edg[0])
        row_d = (row_q == 4'd0) ? row_q : row_q - 4'd1;
      else if (edg[1])
        row_d = (row_q == 4'd14) ? row_q : row_q + 4'd1;
      else if (edg[2])
        col_d = (col_q == 5'd0) ? LEFT_END : col_q - 5'd1;
      else if (edg[3])
        col_d = (col_q >= 5'd19) ? RIGHT_END : col_q + 5'd1;
    end
  end

  // Synchronisers, tick divider, cooldown and game FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      div_q   <= '0;
      cd_q    <= '0;
      tcnt_q  <= '0;
      col_q   <= COL0;
      row_q   <= ROW0;
      vis_q   <= 1'b1;
      lives_q <= LIVES0;
      score_q <= '0;
      state_q <= PLAY;
    end else begin
      s1_q   <= btn;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      div_q  <= tick ? '0 : div_q + DW'(1);
      if (tick && cd_q != 8'd0)
        cd_q <= cd_q - 8'd1;
      unique case (state_q)
        PLAY: begin
          if (hit) begin
            state_q <= HIT;
            vis_q   <= 1'b0;
            tcnt_q  <= '0;
          end else if (row_q == 4'd0) begin
            state_q <= WIN;
            tcnt_q  <= '0;
            if (score_q != 8'hFF)
              score_q <= score_q + 8'd1;
          end else if (moved) begin
            col_q <= col_d;
            row_q <= row_d;
            cd_q  <= CD_LOAD;
          end
        end
        HIT: begin
          if (tick) begin
            if (tcnt_q == HIT_LAST) begin
              if (lives_q > 2'd1) begin
                lives_q <= lives_q - 2'd1;
                col_q   <= COL0;
                row_q   <= ROW0;
                vis_q   <= 1'b1;
                cd_q    <= '0;
                state_q <= PLAY;
              end else begin
                lives_q <= '0;
                vis_q   <= 1'b1;
                state_q <= OVER;
              end
            end else begin
              tcnt_q <= tcnt_q + 16'd1;
              if (tcnt_q[2:0] == 3'd7)
                vis_q <= ~vis_q;
            end
          end
        end
        WIN: begin
          if (tick) begin
            if (tcnt_q == WIN_LAST) begin
              col_q   <= COL0;
              row_q   <= ROW0;
              vis_q   <= 1'b1;
              cd_q    <= '0;
              state_q <= PLAY;
            end else begin
              tcnt_q <= tcnt_q + 16'd1;
            end
          end
        end
        OVER: begin
          if (edg[0]) begin
            lives_q <= LIVES0;
            score_q <= '0;
            col_q   <= COL0;
            row_q   <= ROW0;
            vis_q   <= 1'b1;
            cd_q    <= CD_LOAD;
            state_q <= PLAY;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_frog_controller.sv
// tb_frog_controller: directed scenarios plus randomized moves/collisions
// checked against a grid-level model of the game rules.
`timescale 1ns/1ps
module tb_frog_controller;
  localparam int TD = 4;
  localparam int CD = 2;
  localparam int HT = 20;
  localparam int WT = 6;
  localparam int SL = 3;
`ifdef FROG_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam logic [21:0] RST_OUT =
    {5'd10, 4'd14, 1'b1, 2'(SL), 8'd0, 2'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_col, m_row, m_score;

  frog_if bus();

  frog_controller #(
    .TICK_DIV(TD), .MOVE_COOLDOWN(CD), .HIT_TICKS(HT),
    .WIN_TICKS(WT), .START_LIVES(SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [21:0] outs();
    return {bus.frog_col, bus.frog_row, bus.frog_visible,
            bus.lives, bus.score, bus.game_state};
  endfunction

  function automatic logic [21:0] exp_out(int c, int r, int v,
                                          int l, int s, int st);
    return {5'(c), 4'(r), 1'(v), 2'(l), 8'(s), 2'(st)};
  endfunction

  function automatic bit model_hit(int k, int cx, int cy,
                                   int fc, int fr);
    if (cy != fr) return 1'b0;
    if (k >= 4) return cx == fc;
    if (WRAP) return ((fc - cx + 20) % 20) <= 3;
    return (fc >= cx) && (fc <= cx + 3);
  endfunction

  task automatic model_move(logic [3:0] m);
    if (m[0])      m_row = (m_row > 0) ? m_row - 1 : 0;
    else if (m[1]) m_row = (m_row < 14) ? m_row + 1 : 14;
    else if (m[2]) m_col = (m_col > 0) ? m_col - 1 : (WRAP ? 19 : 0);
    else if (m[3]) m_col = (m_col < 19) ? m_col + 1 : (WRAP ? 0 : 19);
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic park();
    bus.car_cols = '0;
    bus.car_rows = '1;
  endtask

  task automatic put_car(int k, int c, int r);
    bus.car_cols[5*k +: 5] = 5'(c);
    bus.car_rows[4*k +: 4] = 4'(r);
  endtask

  task automatic set_btn(logic [3:0] m);
    {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = m;
  endtask

  task automatic press(logic [3:0] m);
    set_btn(m);
    cyc(3);
    set_btn(4'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic wait_state(logic [1:0] s, int lim, output int n);
    n = 0;
    while (bus.game_state !== s && n < lim) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic climb();
    for (int i = 0; i < 14; i++) begin
      press(4'b0001);
      if (i < 13) cyc(12);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    park();
    set_btn(4'd0);
    cyc(2);
    checks++;
    if (outs() !== RST_OUT) begin
      errors++;
      $display("FAIL reset_held got %h exp %h", outs(), RST_OUT);
    end
    rst = 1'b0;
    cyc(3);
    checks++;
    if (outs() !== RST_OUT) begin
      errors++;
      $display("FAIL reset_idle got %h exp %h", outs(), RST_OUT);
    end
  endtask

  task automatic test_up_moves();
    int n;
    logic [3:0] r0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      r0 = bus.frog_row;
      bus.btn_up = 1'b1;
      n = 0;
      while (bus.frog_row === r0 && n < 8) begin
        cyc(1);
        n++;
      end
      bus.btn_up = 1'b0;
      checks++;
      if (n < 3 || n > 4) begin
        errors++;
        $display("FAIL up_latency%0d got %0d exp 3..4", i, n);
      end
      checks++;
      if (bus.frog_row !== 4'(13 - i) || bus.frog_col !== 5'd10) begin
        errors++;
        $display("FAIL up_pos%0d got %0d,%0d exp 10,%0d",
                 i, bus.frog_col, bus.frog_row, 13 - i);
      end
      cyc(12);
    end
  endtask

  task automatic test_cooldown();
    do_reset();
    bus.btn_up = 1'b1;
    cyc(3);
    bus.btn_up = 1'b0;
    cyc(1);
    bus.btn_up = 1'b1;
    cyc(3);
    bus.btn_up = 1'b0;
    cyc(15);
    checks++;
    if (bus.frog_row !== 4'd13) begin
      errors++;
      $display("FAIL cooldown_row got %0d exp 13", bus.frog_row);
    end
  endtask

  task automatic test_corner();
    int ec;
    do_reset();
    park();
    for (int i = 0; i < 10; i++) begin
      press(4'b0100);
      cyc(12);
    end
    checks++;
    if (bus.frog_col !== 5'd0) begin
      errors++;
      $display("FAIL corner_walk got %0d exp 0", bus.frog_col);
    end
    press(4'b1100);
    cyc(12);
    ec = WRAP ? 19 : 0;
    checks++;
    if (bus.frog_col !== 5'(ec) || bus.frog_row !== 4'd14) begin
      errors++;
      $display("FAIL corner_lr got %0d,%0d exp %0d,14",
               bus.frog_col, bus.frog_row, ec);
    end
    press(4'b1000);
    cyc(12);
    ec = WRAP ? 0 : 1;
    checks++;
    if (bus.frog_col !== 5'(ec)) begin
      errors++;
      $display("FAIL corner_right got %0d exp %0d", bus.frog_col, ec);
    end
    put_car(0, 18, 14);
    cyc(2);
    checks++;
    if (bus.game_state !== 2'(model_hit(0, 18, 14, ec, 14))) begin
      errors++;
      $display("FAIL corner_wide_car got %0d exp %0d",
               bus.game_state, model_hit(0, 18, 14, ec, 14));
    end
    park();
  endtask

  task automatic test_hit();
    int n, n2;
    do_reset();
    park();
    put_car(0, 8, 13);
    press(4'b0001);
    cyc(1);
    checks++;
    if (outs() !== exp_out(10, 13, 0, 3, 0, 1)) begin
      errors++;
      $display("FAIL hit_entry got %h exp %h",
               outs(), exp_out(10, 13, 0, 3, 0, 1));
    end
    cyc(48);
    checks++;
    if (bus.frog_visible !== 1'b1 || bus.game_state !== 2'd1) begin
      errors++;
      $display("FAIL hit_blink got vis %0d st %0d exp 1,1",
               bus.frog_visible, bus.game_state);
    end
    wait_state(2'd0, 200, n2);
    n = 48 + n2;
    checks++;
    if (n < HT * TD - 4 || n > HT * TD + 1) begin
      errors++;
      $display("FAIL hit_duration got %0d exp %0d..%0d",
               n, HT * TD - 4, HT * TD + 1);
    end
    checks++;
    if (outs() !== exp_out(10, 14, 1, 2, 0, 0)) begin
      errors++;
      $display("FAIL hit_respawn got %h exp %h",
               outs(), exp_out(10, 14, 1, 2, 0, 0));
    end
    park();
  endtask

  task automatic test_win();
    int n;
    do_reset();
    park();
    climb();
    wait_state(2'd2, 10, n);
    checks++;
    if (n >= 10 || bus.score !== 8'd1) begin
      errors++;
      $display("FAIL win_entry got st %0d score %0d exp 2,1",
               bus.game_state, bus.score);
    end
    wait_state(2'd0, 60, n);
    checks++;
    if (n < WT * TD - 5 || n > WT * TD + 1) begin
      errors++;
      $display("FAIL win_duration got %0d exp %0d..%0d",
               n, WT * TD - 5, WT * TD + 1);
    end
    checks++;
    if (outs() !== exp_out(10, 14, 1, SL, 1, 0)) begin
      errors++;
      $display("FAIL win_respawn got %h exp %h",
               outs(), exp_out(10, 14, 1, SL, 1, 0));
    end
  endtask

  task automatic test_gameover();
    int n;
    do_reset();
    park();
    climb();
    wait_state(2'd2, 10, n);
    wait_state(2'd0, 60, n);
    put_car(4, 10, 14);
    wait_state(2'd3, 400, n);
    checks++;
    if (outs() !== exp_out(10, 14, 1, 0, 1, 3)) begin
      errors++;
      $display("FAIL gameover got %h exp %h",
               outs(), exp_out(10, 14, 1, 0, 1, 3));
    end
    park();
    cyc(5);
    press(4'b0001);
    cyc(2);
    checks++;
    if (outs() !== exp_out(10, 14, 1, SL, 0, 0)) begin
      errors++;
      $display("FAIL restart got %h exp %h",
               outs(), exp_out(10, 14, 1, SL, 0, 0));
    end
    press(4'b0001);
    cyc(10);
    checks++;
    if (bus.frog_row !== 4'd14) begin
      errors++;
      $display("FAIL restart_cooldown got %0d exp 14", bus.frog_row);
    end
    press(4'b0001);
    cyc(2);
    checks++;
    if (bus.frog_row !== 4'd13) begin
      errors++;
      $display("FAIL restart_move got %0d exp 13", bus.frog_row);
    end
  endtask

  task automatic test_reset_mid_hit();
    put_car(4, 10, 13);
    cyc(10);
    checks++;
    if (bus.game_state !== 2'd1) begin
      errors++;
      $display("FAIL midhit_setup got %0d exp 1", bus.game_state);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (outs() !== RST_OUT) begin
      errors++;
      $display("FAIL midhit_reset got %h exp %h", outs(), RST_OUT);
    end
    park();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random_moves();
    logic [3:0] m;
    logic [21:0] e;
    do_reset();
    park();
    m_col = 10;
    m_row = 14;
    m_score = 0;
    for (int i = 0; i < 30; i++) begin
      m = 4'($urandom_range(1, 15));
      press(m);
      model_move(m);
      if (m_row == 0) begin
        cyc(50);
        m_score++;
        m_row = 14;
        m_col = 10;
      end else begin
        cyc(12);
      end
      e = exp_out(m_col, m_row, 1, SL, m_score, 0);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL rand_move%0d btn %b got %h exp %h",
                 i, m, outs(), e);
      end
    end
  endtask

  task automatic test_random_hits();
    int k, cx, cy;
    bit h;
    for (int i = 0; i < 16; i++) begin
      rst = 1'b1;
      park();
      k = $urandom_range(0, 10);
      cx = (k < 4) ? $urandom_range(4, 13) : $urandom_range(8, 12);
      cy = $urandom_range(13, 14);
      put_car(k, cx, cy);
      cyc(1);
      rst = 1'b0;
      cyc(2);
      h = model_hit(k, cx, cy, 10, 14);
      checks++;
      if (bus.game_state !== 2'(h)) begin
        errors++;
        $display("FAIL rand_hit%0d car %0d at %0d,%0d got %0d exp %0d",
                 i, k, cx, cy, bus.game_state, h);
      end
    end
    rst = 1'b1;
    park();
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    set_btn(4'd0);
    park();
    test_reset();
    test_up_moves();
    test_cooldown();
    test_corner();
    test_hit();
    test_win();
    test_gameover();
    test_reset_mid_hit();
    test_random_moves();
    test_random_hits();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
